// File: rtl/idu_issue_ctrl.sv
// Issue/hazard controller in front of the decode pipe register.
// Tracks outstanding long instructions (mul/div/load) in a small scoreboard
// indexed by the long-instruction ID, detects RAW/WAW/structural hazards,
// allocates IDs at issue and frees them on commit.
// Optional feature macro: IDU_ISSUE_COMMIT_BYPASS_EN -- an entry committing
// this cycle is treated as free/non-matching for same-cycle hazard checks
// and ID selection.
module idu_issue_ctrl #(
  parameter int unsigned ID_W       = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid_i,
  input  logic                  dec_is_long_i,
  input  logic                  dec_rs1_re_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic                  dec_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic                  dec_rd_we_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  issue_ready_i,
  input  logic                  flush_i,
  input  logic                  commit_valid_i,
  input  logic [ID_W-1:0]       commit_id_i,
  output logic                  stall_o,
  output logic                  issue_fire_o,
  output logic                  alloc_valid_o,
  output logic [ID_W-1:0]       alloc_id_o,
  output logic [ID_W:0]         busy_cnt_o,
  output logic                  full_o,
  output logic                  err_o
);

  localparam int unsigned NUM_ID = 1 << ID_W;
  localparam int unsigned CNT_W  = ID_W + 1;

  // Scoreboard state
  logic [NUM_ID-1:0]     valid_q;
  logic [NUM_ID-1:0]     valid_d;
  logic [REG_ADDR_W-1:0] rd_q [NUM_ID];
  logic [REG_ADDR_W-1:0] rd_d [NUM_ID];
  logic [CNT_W-1:0]      busy_cnt_q;
  logic [CNT_W-1:0]      busy_cnt_d;
  logic                  full_q;
  logic                  err_q;
  logic                  err_d;

  // Commit decode and hazard intermediates
  logic [NUM_ID-1:0]     commit_vec;
  logic [NUM_ID-1:0]     commit_hit_vec;
  logic                  commit_hit;
  logic                  commit_miss;
  logic [NUM_ID-1:0]     avail_valid;
  logic                  rs1_match;
  logic                  rs2_match;
  logic                  rd_match;
  logic                  raw_hit;
  logic                  waw_hit;
  logic                  struct_hit;
  logic                  any_free;
  logic [ID_W-1:0]       free_id;
  logic [REG_ADDR_W-1:0] alloc_rd;

  // One-hot decode of the commit bus; a hit only counts against a valid entry
  always_comb begin
    commit_vec = '0;
    if (commit_valid_i) begin
      commit_vec[commit_id_i] = 1'b1;
    end
  end

  assign commit_hit_vec = commit_vec & valid_q;
  assign commit_hit     = |commit_hit_vec;
  assign commit_miss    = commit_valid_i && !commit_hit;

  // Entries considered occupied for this cycle's hazard and free checks
`ifdef IDU_ISSUE_COMMIT_BYPASS_EN
  assign avail_valid = valid_q & ~commit_hit_vec;
`else
  assign avail_valid = valid_q;
`endif

  // Register match against occupied entries and lowest-index free entry search
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    rd_match  = 1'b0;
    any_free  = 1'b0;
    free_id   = '0;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      if (avail_valid[i]) begin
        if (rd_q[i] == dec_rs1_i) rs1_match = 1'b1;
        if (rd_q[i] == dec_rs2_i) rs2_match = 1'b1;
        if (rd_q[i] == dec_rd_i)  rd_match  = 1'b1;
      end
    end
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!avail_valid[i]) begin
        any_free = 1'b1;
        free_id  = ID_W'(i);
      end
    end
  end

  // Hazard classification and issue handshake
  always_comb begin
    raw_hit = (dec_rs1_re_i && (dec_rs1_i != '0) && rs1_match) ||
              (dec_rs2_re_i && (dec_rs2_i != '0) && rs2_match);
    waw_hit = dec_rd_we_i && (dec_rd_i != '0) && rd_match;
    struct_hit = dec_is_long_i && !any_free;
    stall_o = dec_valid_i && !flush_i && (raw_hit || waw_hit || struct_hit);
    issue_fire_o  = dec_valid_i && issue_ready_i && !flush_i && !stall_o;
    alloc_valid_o = issue_fire_o && dec_is_long_i;
    alloc_id_o    = any_free ? free_id : '0;
    alloc_rd      = dec_rd_we_i ? dec_rd_i : '0;
  end

  // Next scoreboard state: commit clears first, allocation overrides on the same index
  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < NUM_ID; i++) begin
      rd_d[i] = rd_q[i];
      if (commit_hit_vec[i]) begin
        valid_d[i] = 1'b0;
      end
      if (alloc_valid_o && (alloc_id_o == ID_W'(i))) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = alloc_rd;
      end
    end
  end

  // Occupancy counter and sticky error for commits to free entries
  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (alloc_valid_o && !commit_hit) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end else if (!alloc_valid_o && commit_hit) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
    err_d = err_q || commit_miss;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      busy_cnt_q <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_ID; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
      full_q     <= (busy_cnt_d == CNT_W'(NUM_ID));
      err_q      <= err_d;
      for (int unsigned i = 0; i < NUM_ID; i++) begin
        rd_q[i] <= rd_d[i];
      end
    end
  end

  assign busy_cnt_o = busy_cnt_q;
  assign full_o     = full_q;
  assign err_o      = err_q;

endmodule

// File: doc/idu_issue_ctrl.md
Name: idu_issue_ctrl

Overview:
Issue/hazard controller placed in front of the decode pipe register.
- Keeps a 4-entry scoreboard of outstanding long instructions (mul/div/load), indexed by the 2-bit long-instruction ID that later returns on the commit bus.
- Each cycle it checks the decoded instruction for RAW, WAW and structural hazards, raises a stall request to ctrl, and allocates an ID when a long instruction issues.
- Frees entries on commit_valid_i/commit_id_i.

Parameters:
- NUM_ID, 4, scoreboard entries; fixed equal to 2^ID_W.
- ID_W, 2, long-instruction ID width.
- REG_ADDR_W, 5, GPR address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- dec_valid_i  in  1  decode slot holds a valid instruction.
- dec_is_long_i  in  1  instruction is a long instruction (needs an ID).
- dec_rs1_re_i  in  1  rs1 is read.
- dec_rs1_i  in  REG_ADDR_W  rs1 address.
- dec_rs2_re_i  in  1  rs2 is read.
- dec_rs2_i  in  REG_ADDR_W  rs2 address.
- dec_rd_we_i  in  1  instruction writes rd.
- dec_rd_i  in  REG_ADDR_W  rd address.
- issue_ready_i  in  1  downstream pipe not stalled by other sources.
- flush_i  in  1  decode slot killed this cycle.
- commit_valid_i  in  1  a long instruction completed.
- commit_id_i  in  ID_W  ID of the completed instruction.
- stall_o  out  1  hazard stall request to ctrl (combinational).
- issue_fire_o  out  1  instruction issues this cycle.
- alloc_valid_o  out  1  a long instruction takes an ID this cycle.
- alloc_id_o  out  ID_W  allocated ID.
- busy_cnt_o  out  ID_W+1  number of outstanding entries (registered).
- full_o  out  1  all entries valid (registered state).
- err_o  out  1  sticky protocol error.

Behaviour:
- State per entry: valid bit plus rd[REG_ADDR_W-1:0]; an entry with rd=x0 is stored with a "no-write" rd of x0.
- Reset (rst=1 at a clk edge): all valid=0, rd=0, busy_cnt_o=0, err_o=0. Outputs after reset: stall_o=0, issue_fire_o=0, alloc_valid_o=0, alloc_id_o=0, full_o=0.
- raw_hit = dec_rsN_re_i && rsN!=0 && (some valid entry with rd==rsN), evaluated for N=1,2.
- waw_hit = dec_rd_we_i && dec_rd_i!=0 && (some valid entry with rd==dec_rd_i).
- struct_hit = dec_is_long_i && no free entry.
- stall_o = dec_valid_i && !flush_i && (raw_hit || waw_hit || struct_hit).
- issue_fire_o = dec_valid_i && issue_ready_i && !flush_i && !stall_o.
- alloc_valid_o = issue_fire_o && dec_is_long_i.
- alloc_id_o = lowest-index free entry, else 0. On alloc the entry sets valid=1 and rd = dec_rd_we_i ? dec_rd_i : 0 at the next edge. Zero latency: the ID is presented in the same cycle as the fire.
- Commit: commit_valid_i with a valid entry clears that entry at the edge.
- Commit to an entry that is already invalid: ignored, and err_o is set to 1 (sticky until rst).
- Same cycle alloc and commit:
  - Both applied.
  - If they target the same index (only possible with the bypass feature), the alloc wins and the entry stays valid with the new rd.
- busy_cnt_o updates:
  - +1 on alloc, -1 on a valid commit, unchanged when both occur.
  - Never wraps; range 0..NUM_ID.
- full_o = (busy_cnt_o==NUM_ID).
- flush_i does not clear the scoreboard (issued long instructions still commit). It only blocks issue and allocation that cycle.
- rst asserted mid-operation: the scoreboard is cleared. Later commits for pre-reset IDs hit invalid entries and set err_o. Ctrl must flush the execution units together with rst.
- dec_is_long_i && !dec_rd_we_i (e.g. a long op with no destination) still allocates and occupies an ID.

Optional Feature:
Macro: IDU_ISSUE_COMMIT_BYPASS_EN.
- Defined: an entry being committed this cycle (commit_valid_i && valid) is treated as free and non-matching for raw_hit, waw_hit, struct_hit and free-entry selection in the same cycle. The dependent instruction issues one cycle earlier.
- Undefined: hazard and free checks use only registered state. A committing entry still blocks for that cycle.

Test Plan:
- Reset, then a long op with rd=x5 and dec_valid_i=1, issue_ready_i=1 → alloc_valid_o=1, alloc_id_o=0, issue_fire_o=1; next cycle busy_cnt_o=1.
- Outstanding ID0 rd=x5; decode add with rs1=x5 → stall_o=1, issue_fire_o=0 until commit_id_i=0. Without bypass, issue happens on the cycle after the commit; with IDU_ISSUE_COMMIT_BYPASS_EN, issue happens in the commit cycle.
- Allocate 4 long ops with rd=x1..x4 → IDs 0,1,2,3, full_o=1. A 5th long op → stall_o=1. Commit ID2 → the next allocation returns alloc_id_o=2.
- Instruction with rs1=x0 and rd=x0 while an entry holds rd=x0 → stall_o=0, issues.
- commit_valid_i=1 with commit_id_i=3 while entry 3 is invalid → err_o=1 and stays 1; busy_cnt_o unchanged.
- flush_i=1 while a long op sits in decode with a free ID → alloc_valid_o=0, busy_cnt_o unchanged. Same cycle commit of ID0 alongside an alloc of ID1 → busy_cnt_o unchanged.
